// File: rtl/mc_control_unit_pkg.sv
// Shared constants, state encoding and the per-state Moore control word
// for the multicycle MIPS control unit.
package mc_ctrl_pkg;

    localparam int OPW   = 6;
    localparam int FNW   = 6;
    localparam int ALUCW = 3;

    typedef enum logic [3:0] {
        FETCH    = 4'd0,
        DECODE   = 4'd1,
        MEMADR   = 4'd2,
        MEMREAD  = 4'd3,
        MEMWB    = 4'd4,
        MEMWRITE = 4'd5,
        EXECUTE  = 4'd6,
        ALUWB    = 4'd7,
        BRANCH   = 4'd8,
        ADDIEXEC = 4'd9,
        ADDIWB   = 4'd10
    } state_t;

    localparam logic [OPW-1:0] OP_RTYPE = 6'b000000;
    localparam logic [OPW-1:0] OP_LW    = 6'b100011;
    localparam logic [OPW-1:0] OP_SW    = 6'b101011;
    localparam logic [OPW-1:0] OP_BEQ   = 6'b000100;
    localparam logic [OPW-1:0] OP_ADDI  = 6'b001000;

    localparam logic [FNW-1:0] FN_ADD = 6'b100000;
    localparam logic [FNW-1:0] FN_SUB = 6'b100010;
    localparam logic [FNW-1:0] FN_AND = 6'b100100;
    localparam logic [FNW-1:0] FN_OR  = 6'b100101;
    localparam logic [FNW-1:0] FN_SLT = 6'b101010;

    localparam logic [ALUCW-1:0] ALU_AND = 3'b000;
    localparam logic [ALUCW-1:0] ALU_OR  = 3'b001;
    localparam logic [ALUCW-1:0] ALU_ADD = 3'b010;
    localparam logic [ALUCW-1:0] ALU_SUB = 3'b110;
    localparam logic [ALUCW-1:0] ALU_SLT = 3'b111;

    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;

    localparam logic [1:0] SRCB_RD2  = 2'b00;
    localparam logic [1:0] SRCB_FOUR = 2'b01;
    localparam logic [1:0] SRCB_IMM  = 2'b10;

    typedef struct packed {
        logic       iord;
        logic       memwrite;
        logic       irwrite;
        logic       regwrite;
        logic       pcsrc;
        logic       alusrca;
        logic       memtoreg;
        logic       regdst;
        logic       pcene;
        logic       branch;
        logic [1:0] alusrcb;
        logic [1:0] aluop;
    } ctrl_t;

    // branch marks the state whose PC enable is qualified by Zero
    function automatic ctrl_t moore_ctrl(input state_t s);
        ctrl_t c;
        c         = '0;
        c.alusrcb = SRCB_RD2;
        c.aluop   = ALUOP_ADD;
        case (s)
            FETCH: begin
                c.irwrite = 1'b1;
                c.alusrcb = SRCB_FOUR;
                c.pcene   = 1'b1;
            end
            DECODE:   c.alusrcb = SRCB_IMM;
            MEMADR: begin
                c.alusrca = 1'b1;
                c.alusrcb = SRCB_IMM;
            end
            MEMREAD:  c.iord = 1'b1;
            MEMWB: begin
                c.memtoreg = 1'b1;
                c.regwrite = 1'b1;
            end
            MEMWRITE: begin
                c.iord     = 1'b1;
                c.memwrite = 1'b1;
            end
            EXECUTE: begin
                c.alusrca = 1'b1;
                c.aluop   = ALUOP_FUNCT;
            end
            ALUWB: begin
                c.regdst   = 1'b1;
                c.regwrite = 1'b1;
            end
            BRANCH: begin
                c.alusrca = 1'b1;
                c.aluop   = ALUOP_SUB;
                c.pcsrc   = 1'b1;
                c.branch  = 1'b1;
            end
            ADDIEXEC: begin
                c.alusrca = 1'b1;
                c.alusrcb = SRCB_IMM;
            end
            ADDIWB:   c.regwrite = 1'b1;
            default:  c.alusrcb = SRCB_RD2;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/mc_control_unit_if.sv
// Control bus between the control unit (master) and the datapath (slave).
interface mc_control_unit_if;
    import mc_ctrl_pkg::*;

    logic [OPW-1:0]   op;
    logic [FNW-1:0]   funct;
    logic             Zero;
    logic             IorD;
    logic             MemWrite;
    logic             IRWrite;
    logic             RegWrite;
    logic             PCSrc;
    logic             ALUSrcA;
    logic             MemtoReg;
    logic             RegDst;
    logic             PCene;
    logic [1:0]       ALUSrcB;
    logic [ALUCW-1:0] ALUSControl;
    logic             illegal_o;
    logic [3:0]       state_o;

    modport master (
        input  op, funct, Zero,
        output IorD, MemWrite, IRWrite, RegWrite, PCSrc, ALUSrcA, MemtoReg,
               RegDst, PCene, ALUSrcB, ALUSControl, illegal_o, state_o
    );

    modport slave (
        output op, funct, Zero,
        input  IorD, MemWrite, IRWrite, RegWrite, PCSrc, ALUSrcA, MemtoReg,
               RegDst, PCene, ALUSrcB, ALUSControl, illegal_o, state_o
    );

endinterface

// File: rtl/mc_control_unit_alu_decoder.sv
// ALU operation select from the FSM's aluop class and the R-type funct field.
module alu_decoder
    import mc_ctrl_pkg::*;
(
    input  logic [FNW-1:0]   funct,
    input  logic [1:0]       aluop,
    output logic [ALUCW-1:0] alu_control
);

    // Unknown funct codes fall back to ADD so the writeback still happens
    always_comb begin
        alu_control = ALU_ADD;
        case (aluop)
            ALUOP_ADD: alu_control = ALU_ADD;
            ALUOP_SUB: alu_control = ALU_SUB;
            ALUOP_FUNCT: begin
                case (funct)
                    FN_ADD:  alu_control = ALU_ADD;
                    FN_SUB:  alu_control = ALU_SUB;
                    FN_AND:  alu_control = ALU_AND;
                    FN_OR:   alu_control = ALU_OR;
                    FN_SLT:  alu_control = ALU_SLT;
                    default: alu_control = ALU_ADD;
                endcase
            end
            default: alu_control = ALU_ADD;
        endcase
    end

endmodule

// File: rtl/mc_control_unit.sv
// Multicycle MIPS control FSM: registered Moore control word, Zero-qualified
// PC enable in BRANCH, and write strobes gated off while reset is held.
module mc_control_unit
    import mc_ctrl_pkg::*;
(
    input  logic              clk_dp,
    input  logic              rst,
    mc_control_unit_if.master bus
);

    state_t           state_r;
    state_t           next_state_s;
    ctrl_t            ctrl_r;
    logic             illegal_s;
    logic [ALUCW-1:0] alu_control_s;

    // Next-state selection; op is only consulted in DECODE and MEMADR
    always_comb begin
        next_state_s = FETCH;
        case (state_r)
            FETCH: next_state_s = DECODE;
            DECODE: begin
                case (bus.op)
                    OP_LW, OP_SW: next_state_s = MEMADR;
                    OP_RTYPE:     next_state_s = EXECUTE;
                    OP_BEQ:       next_state_s = BRANCH;
                    OP_ADDI:      next_state_s = ADDIEXEC;
                    default:      next_state_s = FETCH;
                endcase
            end
            MEMADR: begin
                if (bus.op == OP_LW) begin
                    next_state_s = MEMREAD;
                end else if (bus.op == OP_SW) begin
                    next_state_s = MEMWRITE;
                end else begin
                    next_state_s = FETCH;
                end
            end
            MEMREAD:  next_state_s = MEMWB;
            MEMWB:    next_state_s = FETCH;
            MEMWRITE: next_state_s = FETCH;
            EXECUTE:  next_state_s = ALUWB;
            ALUWB:    next_state_s = FETCH;
            BRANCH:   next_state_s = FETCH;
            ADDIEXEC: next_state_s = ADDIWB;
            ADDIWB:   next_state_s = FETCH;
            default:  next_state_s = FETCH;
        endcase
    end

    // Unsupported opcode flag, meaningful only while decoding
    always_comb begin
        illegal_s = 1'b0;
        if (state_r == DECODE) begin
            case (bus.op)
                OP_LW, OP_SW, OP_RTYPE, OP_BEQ, OP_ADDI: illegal_s = 1'b0;
                default:                                 illegal_s = 1'b1;
            endcase
        end else begin
            illegal_s = 1'b0;
        end
    end

    // State and control word registered together so outputs never glitch on state decode
    always_ff @(posedge clk_dp) begin
        if (!rst) begin
            state_r <= FETCH;
            ctrl_r  <= moore_ctrl(FETCH);
        end else begin
            state_r <= next_state_s;
            ctrl_r  <= moore_ctrl(next_state_s);
        end
    end

    alu_decoder u_alu_decoder (
        .funct       (bus.funct),
        .aluop       (ctrl_r.aluop),
        .alu_control (alu_control_s)
    );

    assign bus.IorD        = ctrl_r.iord;
    assign bus.PCSrc       = ctrl_r.pcsrc;
    assign bus.ALUSrcA     = ctrl_r.alusrca;
    assign bus.MemtoReg    = ctrl_r.memtoreg;
    assign bus.RegDst      = ctrl_r.regdst;
    assign bus.ALUSrcB     = ctrl_r.alusrcb;
    assign bus.ALUSControl = alu_control_s;
    assign bus.state_o     = state_r;

    // Write strobes are killed the moment reset is asserted, even mid-instruction
    assign bus.MemWrite  = ctrl_r.memwrite & rst;
    assign bus.IRWrite   = ctrl_r.irwrite & rst;
    assign bus.RegWrite  = ctrl_r.regwrite & rst;
    assign bus.PCene     = (ctrl_r.pcene | (ctrl_r.branch & bus.Zero)) & rst;
    assign bus.illegal_o = illegal_s & rst;

endmodule

// File: tb/tb_mc_control_unit.sv
// Self-checking bench for mc_control_unit: instruction table, hand-written
// corner sequences and randomized instructions against a per-cycle model.
module tb_mc_control_unit;
    import mc_ctrl_pkg::*;

    logic clk_dp;
    logic rst;
    int   tests;
    int   fails;

    mc_control_unit_if bus ();

    mc_control_unit dut (
        .clk_dp (clk_dp),
        .rst    (rst),
        .bus    (bus.master)
    );

    initial clk_dp = 1'b0;
    always #5 clk_dp = ~clk_dp;

    typedef struct packed {
        logic [3:0] st;
        logic       iord, memwrite, irwrite, regwrite, pcsrc, alusrca, memtoreg, regdst, pcene;
        logic [1:0] srcb;
        logic [2:0] aluc;
        logic       ill;
    } obs_t;

    typedef struct {
        logic [5:0] op;
        logic [5:0] fn;
        logic       z;
        int         cycles;
        int         n_rw;
        int         n_mw;
        int         n_pc;
        int         n_ill;
        logic [2:0] alu2;
        string      name;
    } vec_t;

    function automatic bit supported(input logic [5:0] o);
        return (o == 6'b100011) || (o == 6'b101011) || (o == 6'b000000) ||
               (o == 6'b000100) || (o == 6'b001000);
    endfunction

    function automatic logic [2:0] fdec(input logic [5:0] fn);
        case (fn)
            6'b100000: return 3'b010;
            6'b100010: return 3'b110;
            6'b100100: return 3'b000;
            6'b100101: return 3'b001;
            6'b101010: return 3'b111;
            default:   return 3'b010;
        endcase
    endfunction

    // What the datapath should see in a cycle of the given step of an instruction
    function automatic obs_t expect_out(input int code, input logic [5:0] o,
                                        input logic [5:0] fn, input logic z);
        obs_t e;
        e      = '0;
        e.st   = 4'(code);
        e.aluc = 3'b010;
        case (code)
            0: begin e.irwrite = 1'b1; e.srcb = 2'b01; e.pcene = 1'b1; end
            1: begin e.srcb = 2'b10; e.ill = !supported(o); end
            2: begin e.alusrca = 1'b1; e.srcb = 2'b10; end
            3: e.iord = 1'b1;
            4: begin e.memtoreg = 1'b1; e.regwrite = 1'b1; end
            5: begin e.iord = 1'b1; e.memwrite = 1'b1; end
            6: begin e.alusrca = 1'b1; e.aluc = fdec(fn); end
            7: begin e.regdst = 1'b1; e.regwrite = 1'b1; end
            8: begin e.alusrca = 1'b1; e.aluc = 3'b110; e.pcsrc = 1'b1; e.pcene = z; end
            9: begin e.alusrca = 1'b1; e.srcb = 2'b10; end
            10: e.regwrite = 1'b1;
            default: e.st = 4'hf;
        endcase
        return e;
    endfunction

    function automatic obs_t observe();
        obs_t a;
        a = {bus.state_o, bus.IorD, bus.MemWrite, bus.IRWrite, bus.RegWrite, bus.PCSrc,
             bus.ALUSrcA, bus.MemtoReg, bus.RegDst, bus.PCene, bus.ALUSrcB,
             bus.ALUSControl, bus.illegal_o};
        return a;
    endfunction

    task automatic cmp(input string nm, input int act, input int exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    task automatic cmpv(input string nm, input obs_t act, input obs_t exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Entered just after a rising edge; checks mid-cycle, returns just after the next edge
    task automatic check_cycle(input int code, input string nm);
        @(negedge clk_dp);
        cmpv(nm, observe(), expect_out(code, bus.op, bus.funct, bus.Zero));
        @(posedge clk_dp);
        #1;
    endtask

    task automatic run_model_instr(input logic [5:0] o, input logic [5:0] fn, input bit rnd_zero);
        int s[$];
        bus.op    = o;
        bus.funct = fn;
        case (o)
            6'b100011: s = '{0, 1, 2, 3, 4};
            6'b101011: s = '{0, 1, 2, 5};
            6'b000000: s = '{0, 1, 6, 7};
            6'b000100: s = '{0, 1, 8};
            6'b001000: s = '{0, 1, 9, 10};
            default:   s = '{0, 1};
        endcase
        foreach (s[i]) begin
            if (rnd_zero) bus.Zero = 1'($urandom_range(0, 1));
            check_cycle(s[i], $sformatf("op%b step%0d", o, i));
        end
    endtask

    // Counts cycles and strobes until the unit comes back to FETCH
    task automatic measure(input vec_t v);
        int cyc, rw, mw, pc, ill;
        logic [2:0] alu2;
        bit done;
        cyc = 0; rw = 0; mw = 0; pc = 0; ill = 0; alu2 = 3'b000; done = 1'b0;
        bus.op = v.op; bus.funct = v.fn; bus.Zero = v.z;
        while (!done && cyc < 8) begin
            @(negedge clk_dp);
            rw  += int'(bus.RegWrite);
            mw  += int'(bus.MemWrite);
            pc  += int'(bus.PCene);
            ill += int'(bus.illegal_o);
            if (cyc == 2) alu2 = bus.ALUSControl;
            cyc++;
            @(posedge clk_dp);
            #1;
            if (bus.state_o == 4'd0) done = 1'b1;
        end
        cmp({v.name, " cycles"}, cyc, v.cycles);
        cmp({v.name, " regwrite"}, rw, v.n_rw);
        cmp({v.name, " memwrite"}, mw, v.n_mw);
        cmp({v.name, " pcene"}, pc, v.n_pc);
        cmp({v.name, " illegal"}, ill, v.n_ill);
        if (v.cycles >= 3) cmp({v.name, " alu step2"}, int'(alu2), int'(v.alu2));
    endtask

    vec_t tbl[12];

    initial begin
        logic [5:0] o, fn;
        tests = 0;
        fails = 0;
        tbl[0]  = '{6'b100011, 6'b000000, 1'b0, 5, 1, 0, 1, 0, 3'b010, "lw"};
        tbl[1]  = '{6'b101011, 6'b000000, 1'b1, 4, 0, 1, 1, 0, 3'b010, "sw"};
        tbl[2]  = '{6'b000000, 6'b100010, 1'b0, 4, 1, 0, 1, 0, 3'b110, "r_sub"};
        tbl[3]  = '{6'b000000, 6'b101010, 1'b1, 4, 1, 0, 1, 0, 3'b111, "r_slt"};
        tbl[4]  = '{6'b000000, 6'b100100, 1'b0, 4, 1, 0, 1, 0, 3'b000, "r_and"};
        tbl[5]  = '{6'b000000, 6'b100101, 1'b0, 4, 1, 0, 1, 0, 3'b001, "r_or"};
        tbl[6]  = '{6'b000000, 6'b100000, 1'b0, 4, 1, 0, 1, 0, 3'b010, "r_add"};
        tbl[7]  = '{6'b000000, 6'b111111, 1'b0, 4, 1, 0, 1, 0, 3'b010, "r_badfunct"};
        tbl[8]  = '{6'b000100, 6'b000000, 1'b1, 3, 0, 0, 2, 0, 3'b110, "beq_taken"};
        tbl[9]  = '{6'b000100, 6'b000000, 1'b0, 3, 0, 0, 1, 0, 3'b110, "beq_not"};
        tbl[10] = '{6'b001000, 6'b000000, 1'b1, 4, 1, 0, 1, 0, 3'b010, "addi"};
        tbl[11] = '{6'b111111, 6'b000000, 1'b1, 2, 0, 0, 1, 1, 3'b010, "illegal"};

        rst = 1'b0; bus.op = 6'b100011; bus.funct = 6'b000000; bus.Zero = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk_dp);
            cmp("reset strobes", int'({bus.MemWrite, bus.IRWrite, bus.RegWrite, bus.PCene, bus.illegal_o}), 0);
        end
        @(posedge clk_dp);
        #1;
        rst = 1'b1;
        run_model_instr(6'b100011, 6'b000000, 1'b0);

        foreach (tbl[i]) measure(tbl[i]);

        // beq: Zero high during DECODE must not leak into the PC enable
        bus.op = 6'b000100; bus.Zero = 1'b1;
        check_cycle(0, "beq fetch");
        check_cycle(1, "beq decode zero1");
        bus.Zero = 1'b0;
        @(negedge clk_dp);
        cmp("beq zero0 pcene", int'(bus.PCene), 0);
        cmp("beq zero0 state", int'(bus.state_o), 8);
        bus.Zero = 1'b1;
        #1;
        cmp("beq zero1 pcene", int'(bus.PCene), 1);
        cmp("beq zero1 pcsrc", int'(bus.PCSrc), 1);
        @(posedge clk_dp);
        #1;

        // Reset landing in MEMADR of an sw: no store may escape
        bus.op = 6'b101011; bus.Zero = 1'b0;
        check_cycle(0, "sw fetch");
        check_cycle(1, "sw decode");
        rst = 1'b0;
        @(negedge clk_dp);
        cmp("midrst state", int'(bus.state_o), 2);
        cmp("midrst strobes", int'({bus.MemWrite, bus.IRWrite, bus.RegWrite, bus.PCene, bus.illegal_o}), 0);
        @(posedge clk_dp);
        #1;
        cmp("midrst after edge", int'(bus.state_o), 0);
        cmp("midrst memwrite", int'(bus.MemWrite), 0);
        rst = 1'b1;
        run_model_instr(6'b101011, 6'b000000, 1'b1);

        for (int n = 0; n < 150; n++) begin
            case ($urandom_range(0, 5))
                0: o = 6'b100011;
                1: o = 6'b101011;
                2: o = 6'b000000;
                3: o = 6'b000100;
                4: o = 6'b001000;
                default: begin
                    o = 6'($urandom);
                    if (supported(o)) o = 6'b111111;
                end
            endcase
            case ($urandom_range(0, 5))
                0: fn = 6'b100000;
                1: fn = 6'b100010;
                2: fn = 6'b100100;
                3: fn = 6'b100101;
                4: fn = 6'b101010;
                default: fn = 6'($urandom);
            endcase
            run_model_instr(o, fn, 1'b1);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/mc_control_unit.md
Name: mc_control_unit

Overview:
- Multicycle MIPS control unit; sits directly upstream of the datapath.
- Consumes op, funct and Zero from the datapath; drives every datapath control strobe and mux select.
- Moore FSM with one Mealy term (PCene, from Zero) plus a combinational ALU decoder.
- Supports lw, sw, R-type (add, sub, and, or, slt), beq and addi.

Parameters:
- OPW, 6, opcode width
- FNW, 6, funct width
- ALUCW, 3, ALU control width

Ports:
- clk_dp  in  1  system clock; all state changes on rising edge
- rst  in  1  synchronous active-low reset
- op  in  6  instruction opcode (IR[31:26])
- funct  in  6  R-type function (IR[5:0])
- Zero  in  1  ALU zero flag, combinational, same cycle
- IorD  out  1  memory address: 0=PC, 1=ALUout
- MemWrite  out  1  system memory write enable
- IRWrite  out  1  instruction register load
- RegWrite  out  1  register file write enable
- PCSrc  out  1  PC source: 0=ALU result, 1=ALUout
- ALUSrcA  out  1  ALU A: 0=PC, 1=RD1 register
- MemtoReg  out  1  WD3 source: 0=ALUout, 1=Data register
- RegDst  out  1  write register: 0=rt, 1=rd
- PCene  out  1  PC load enable
- ALUSrcB  out  2  ALU B: 00=RD2, 01=const 4, 10=sign-ext imm
- ALUSControl  out  3  ALU operation select
- illegal_o  out  1  one-cycle pulse in DECODE on unsupported opcode
- state_o  out  4  current state encoding, for debug

Behaviour:
- Reset: rst sampled low at a clock edge sets state to FETCH.
- While rst is low, all write strobes are forced to 0 combinationally: MemWrite, IRWrite, RegWrite, PCene, illegal_o.
- First fetch occurs in the first cycle after rst returns high.
- Unlisted outputs in every state default to 0, with ALUSControl=ADD.
- FETCH: IorD=0, IRWrite=1, ALUSrcA=0, ALUSrcB=01, ALUSControl=ADD, PCSrc=0, PCene=1; next DECODE.
- DECODE: ALUSrcA=0, ALUSrcB=10, ALUSControl=ADD; computes the branch target into ALUout. The immediate is not shifted; branch offsets are byte offsets.
- DECODE next state: lw/sw -> MEMADR; R-type -> EXECUTE; beq -> BRANCH; addi -> ADDIEXEC; other -> FETCH with illegal_o=1.
- MEMADR: ALUSrcA=1, ALUSrcB=10, ADD; next MEMREAD if op=lw, MEMWRITE if op=sw.
- MEMREAD: IorD=1; next MEMWB.
- MEMWB: RegDst=0, MemtoReg=1, RegWrite=1; next FETCH.
- MEMWRITE: IorD=1, MemWrite=1; next FETCH.
- EXECUTE: ALUSrcA=1, ALUSrcB=00, ALUSControl=funct-decoded; next ALUWB.
- ALUWB: RegDst=1, MemtoReg=0, RegWrite=1; next FETCH.
- BRANCH: ALUSrcA=1, ALUSrcB=00, ALUSControl=SUB, PCSrc=1, PCene=Zero; next FETCH.
- ADDIEXEC: ALUSrcA=1, ALUSrcB=10, ADD; next ADDIWB.
- ADDIWB: RegDst=0, MemtoReg=0, RegWrite=1; next FETCH.
- Cycle counts per instruction: lw 5, sw 4, R-type 4, addi 4, beq 3, illegal 2.
- ALU codes: AND=000, OR=001, ADD=010, SUB=110, SLT=111.
- funct decode: 100000->ADD, 100010->SUB, 100100->AND, 100101->OR, 101010->SLT. Any other funct -> ADD, and writeback still occurs.
- Decode is combinational on op/funct; op is sampled only in DECODE and MEMADR. IR is stable there because IRWrite is asserted only in FETCH.
- Zero affects only PCene, and only in BRANCH; Zero toggling in any other state has no effect.
- Reset asserted mid-instruction: the next edge returns to FETCH; strobes are suppressed in the reset cycle, so no partial memory or register write occurs.
- state_o encoding: FETCH=0, DECODE=1, MEMADR=2, MEMREAD=3, MEMWB=4, MEMWRITE=5, EXECUTE=6, ALUWB=7, BRANCH=8, ADDIEXEC=9, ADDIWB=10. Codes 11-15 are unreachable; if entered, next state is FETCH.

Decomposition:
- Package mc_ctrl_pkg holds:
  - state localparams (FETCH..ADDIWB);
  - opcode constants: OP_RTYPE=000000, OP_LW=100011, OP_SW=101011, OP_BEQ=000100, OP_ADDI=001000;
  - funct constants;
  - ALU control codes;
  - ALUSrcB codes.
- Sub-module alu_decoder: combinational, inputs funct and a 2-bit aluop (00=ADD, 01=SUB, 10=funct), output ALUSControl.
- The FSM instantiates alu_decoder and drives aluop per state.

Test Plan:
- Reset: hold rst=0 for 3 cycles with op=lw -> all strobes 0 throughout; first cycle after release state_o=0, IRWrite=1, PCene=1, ALUSrcB=01.
- lw: op=100011 -> state_o sequence 0,1,2,3,4,0. MemWB cycle has RegWrite=1, MemtoReg=1, RegDst=0; MemWrite is never 1.
- sw then R-type sub: op=101011 -> MemWrite=1 only in state 5. Then op=000000, funct=100010 -> EXECUTE has ALUSControl=110, ALUWB has RegDst=1, RegWrite=1.
- beq: op=000100 with Zero=1 in BRANCH -> PCene=1, PCSrc=1. Repeat with Zero=0 -> PCene=0. Zero=1 in DECODE has no effect.
- addi and slt: op=001000 -> states 0,1,9,10,0, RegDst=0 at writeback. R-type funct=101010 -> ALUSControl=111.
- Illegal and mid-instruction reset: op=111111 -> illegal_o=1 in DECODE, then FETCH. rst=0 during state 2 of an sw -> no MemWrite pulse, state 0 after the edge.
